if_fetch_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register for the 5-stage RISC-V core. It sits directly upstream of the ID/EX register bank.

- Owns the fetch PC and the instruction-memory request handshake.
- Holds the IF/ID register (instruction, PC, valid).
- Detects load-use hazards against the instruction currently in ID/EX and stalls fetch when one is found.
- Generates the `id_flush` that turns the next ID/EX load into a bubble.

---
 rtl/core_pkg.sv | 38 +++
 rtl/hazard_detect.sv | 23 ++
 rtl/if_fetch_stage.sv | 120 ++++++++++++
 tb/tb_if_fetch_stage.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the 5-stage RISC-V core.
package core_pkg;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;

  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

  localparam int RS1_MSB = 19;
  localparam int RS1_LSB = 15;
  localparam int RS2_MSB = 24;
  localparam int RS2_LSB = 20;

  localparam if_id_t IF_ID_BUBBLE = '{
    instr: BUBBLE_INSTR,
    pc:    32'h0,
    valid: 1'b0
  };

  function automatic logic [4:0] rs1_of(input logic [31:0] instr);
    return instr[RS1_MSB:RS1_LSB];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] instr);
    return instr[RS2_MSB:RS2_LSB];
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard check between the load in ID/EX and the
// instruction waiting in IF/ID.
module hazard_detect
  import core_pkg::*;
(
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] if_id_instr,
  input  logic        if_id_valid,
  output logic        load_use
);

  logic rd_nz;
  logic src_hit;

  assign rd_nz   = (ex_rd != 5'd0);
  assign src_hit = (ex_rd == rs1_of(if_id_instr))
                 | (ex_rd == rs2_of(if_id_instr));

  assign load_use = ex_mem_read & rd_nz
                  & if_id_valid & src_hit;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch FSM with IF/ID register, load-use stall
// and ID/EX flush generation.
module if_fetch_stage
  import core_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic        stall,
  output logic        id_flush
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_q, hold_d;
  logic [31:0]  rbuf_q, rbuf_d;
  if_id_t       ifid_q, ifid_d;
  logic [31:0]  tgt;
  logic         load_use;

  assign if_id_instr = ifid_q.instr;
  assign if_id_pc    = ifid_q.pc;
  assign if_id_valid = ifid_q.valid;
  assign imem_addr   = pc_q;
  assign tgt         = {redirect_pc[31:2], 2'b00};

  hazard_detect u_hazard (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .if_id_instr (ifid_q.instr),
    .if_id_valid (ifid_q.valid),
    .load_use    (load_use)
  );

  assign stall    = load_use & ~redirect;
  assign id_flush = redirect | load_use | ~ifid_q.valid;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    hold_d   = hold_q;
    rbuf_d   = rbuf_q;
    ifid_d   = ifid_q;
    imem_req = 1'b1;
    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          ifid_d = IF_ID_BUBBLE;
          if (imem_ready) begin
            pc_d = tgt;
          end else begin
            rbuf_d  = tgt;
            state_d = DISCARD;
          end
        end else if (imem_ready) begin
          pc_d = pc_q + PC_STEP;
          if (stall) begin
            hold_d  = imem_rdata;
            state_d = HOLD;
          end else begin
            ifid_d = '{imem_rdata, pc_q, 1'b1};
          end
        end else if (!stall) begin
          ifid_d = IF_ID_BUBBLE;
        end
      end
      HOLD: begin
        imem_req = 1'b0;
        if (redirect) begin
          ifid_d  = IF_ID_BUBBLE;
          hold_d  = BUBBLE_INSTR;
          pc_d    = tgt;
          state_d = FETCH;
        end else if (!stall) begin
          ifid_d  = '{hold_q, pc_q - PC_STEP, 1'b1};
          state_d = FETCH;
        end
      end
      DISCARD: begin
        // The in-flight response belongs to the old path; drop it.
        ifid_d = IF_ID_BUBBLE;
        if (redirect) rbuf_d = tgt;
        if (imem_ready) begin
          pc_d    = redirect ? tgt : rbuf_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= PC_RESET;
      hold_q  <= 32'h0;
      rbuf_q  <= 32'h0;
      ifid_q  <= IF_ID_BUBBLE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      rbuf_q  <= rbuf_d;
      ifid_q  <= ifid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: sequential fetch, stalls,
// redirects, discard path, PC wrap and async reset.
module tb_if_fetch_stage;
  import core_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] ADD = 32'h0041_82B3;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic        stall;
  logic        id_flush;

  int checks = 0;
  int errors = 0;

  if_fetch_stage #(.PC_RESET(32'h0000_0100)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_valid (if_id_valid),
    .stall       (stall),
    .id_flush    (id_flush)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_ifid(input string tag,
                          input logic [31:0] ins,
                          input logic [31:0] pc,
                          input logic v);
    chk({tag, "_instr"}, if_id_instr, ins);
    chk({tag, "_pc"}, if_id_pc, pc);
    chk({tag, "_valid"}, {31'b0, if_id_valid}, {31'b0, v});
  endtask

  initial begin
    reset       = 1'b1;
    imem_ready  = 1'b1;
    imem_rdata  = NOP;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    ex_mem_read = 1'b0;
    ex_rd       = 5'd0;
    #12;
    chk("rst_req", {31'b0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'h100);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_flush", {31'b0, id_flush}, 32'd1);
    chk_ifid("rst", 32'h0, 32'h0, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    // Zero-wait sequential fetch
    tick();
    chk_ifid("seq0", NOP, 32'h100, 1'b1);
    chk("seq0_flush", {31'b0, id_flush}, 32'd0);
    tick();
    chk("seq1_pc", if_id_pc, 32'h104);
    imem_rdata = ADD;
    tick();
    chk("seq2_pc", if_id_pc, 32'h108);
    tick();
    chk_ifid("add", ADD, 32'h10C, 1'b1);
    chk("add_addr", imem_addr, 32'h110);

    // Load-use on rs1 (x3)
    ex_mem_read = 1'b1;
    ex_rd       = 5'd3;
    imem_rdata  = NOP;
    #1;
    chk("lu_stall", {31'b0, stall}, 32'd1);
    chk("lu_flush", {31'b0, id_flush}, 32'd1);
    tick();
    chk_ifid("lu_hold", ADD, 32'h10C, 1'b1);
    chk("lu_req", {31'b0, imem_req}, 32'd0);
    ex_mem_read = 1'b0;
    #1;
    chk("lu_clr", {31'b0, stall}, 32'd0);
    tick();
    chk_ifid("lu_resume", NOP, 32'h110, 1'b1);
    chk("lu_addr", imem_addr, 32'h114);
    chk("lu_req2", {31'b0, imem_req}, 32'd1);

    // x0 never hazards
    ex_mem_read = 1'b1;
    ex_rd       = 5'd0;
    #1;
    chk("x0_stall", {31'b0, stall}, 32'd0);
    ex_mem_read = 1'b0;
    imem_rdata  = ADD;
    tick();
    chk_ifid("add2", ADD, 32'h114, 1'b1);

    // Load-use on rs2 (x4), then redirect while in HOLD
    ex_mem_read = 1'b1;
    ex_rd       = 5'd4;
    imem_rdata  = 32'h0BAD_0013;
    #1;
    chk("rs2_stall", {31'b0, stall}, 32'd1);
    tick();
    chk("hold_state", {30'b0, dut.state_q}, {30'b0, HOLD});
    chk("hold_req", {31'b0, imem_req}, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    #1;
    chk("rdh_stall", {31'b0, stall}, 32'd0);
    chk("rdh_flush", {31'b0, id_flush}, 32'd1);
    tick();
    chk_ifid("rdh_bub", 32'h0, 32'h0, 1'b0);
    chk("rdh_addr", imem_addr, 32'h200);
    chk("rdh_req", {31'b0, imem_req}, 32'd1);
    redirect    = 1'b0;
    ex_mem_read = 1'b0;
    imem_rdata  = NOP;
    tick();
    chk_ifid("rdh_tgt", NOP, 32'h200, 1'b1);

    // Redirect with an outstanding request
    imem_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    tick();
    chk("dis_state", {30'b0, dut.state_q}, {30'b0, DISCARD});
    chk("dis_addr", imem_addr, 32'h204);
    chk("dis_req", {31'b0, imem_req}, 32'd1);
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_ifid("dis_wait", 32'h0, 32'h0, 1'b0);
      chk("dis_waddr", imem_addr, 32'h204);
    end
    imem_ready = 1'b1;
    imem_rdata = 32'hBADB_AD13;
    tick();
    chk("dis_fetch", {30'b0, dut.state_q}, {30'b0, FETCH});
    chk("dis_tgt", imem_addr, 32'h300);
    chk_ifid("dis_drop", 32'h0, 32'h0, 1'b0);
    imem_rdata = NOP;
    tick();
    chk_ifid("dis_new", NOP, 32'h300, 1'b1);

    // PC wrap
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    chk_ifid("wrap_bub", 32'h0, 32'h0, 1'b0);
    redirect = 1'b0;
    tick();
    chk("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0);
    tick();
    chk("wrap_pc2", if_id_pc, 32'h0);

    // Async reset mid-handshake
    imem_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_addr", imem_addr, 32'h100);
    chk("arst_req", {31'b0, imem_req}, 32'd1);
    chk_ifid("arst", 32'h0, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
